// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction fetch and data ports share one
// fixed-latency memory. Data has priority, bounded by a starvation streak limit.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned DM_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stallreq_o
);

  localparam logic [3:0] LastCnt   = 4'(MEM_LAT - 1);
  localparam logic [3:0] StreakMax = 4'(DM_MAX);

  typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic        owner_dm_q, owner_dm_d;
  logic        mem_ce_q, mem_ce_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_sel_q, mem_sel_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        grant_dm;

  // Data wins unless fetch has already been passed over DM_MAX times in a row.
  assign grant_dm = dm_req_i & ~(if_req_i & (streak_q == StreakMax));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    owner_dm_d  = owner_dm_q;
    mem_ce_d    = mem_ce_q;
    mem_we_d    = mem_we_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_data_d   = if_data_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      StIdle: begin
        if (!if_req_i) begin
          streak_d = '0;
        end
        if (grant_dm) begin
          state_d     = StAcc;
          cnt_d       = '0;
          owner_dm_d  = 1'b1;
          mem_ce_d    = 1'b1;
          mem_we_d    = dm_we_i;
          mem_sel_d   = dm_sel_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          if (if_req_i && (streak_q != StreakMax)) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (if_req_i) begin
          state_d     = StAcc;
          cnt_d       = '0;
          owner_dm_d  = 1'b0;
          mem_ce_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_sel_d   = 4'b1111;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      StAcc: begin
        if (cnt_q == LastCnt) begin
          state_d  = StResp;
          mem_ce_d = 1'b0;
          if (owner_dm_q) begin
            dm_ack_d = 1'b1;
            // Writes leave the previous read data visible.
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata_i;
            end
          end else begin
            if_ack_d  = 1'b1;
            if_data_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      streak_q    <= '0;
      owner_dm_q  <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_data_q   <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      owner_dm_q  <= owner_dm_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_data_q   <= if_data_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_data_o   = if_data_q;
  assign dm_ack_o    = dm_ack_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = mem_we_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign stallreq_o  = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all cycles
// checked against a transaction-timeline reference model.
module tb_mem_arbiter;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned DM_MAX  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_data_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        stallreq_o;

  mem_arbiter #(
    .MEM_LAT(MEM_LAT),
    .DM_MAX (DM_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_ack_o   (if_ack_o),
    .if_data_o  (if_data_o),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_sel_i   (dm_sel_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_ack_o   (dm_ack_o),
    .dm_rdata_o (dm_rdata_o),
    .mem_ce_o   (mem_ce_o),
    .mem_we_o   (mem_we_o),
    .mem_sel_o  (mem_sel_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: one access occupies MEM_LAT+1 cycles after its grant
  // edge (MEM_LAT with memory enabled, then one ack cycle).
  int          m_left   = 0;
  bit          m_who_dm = 1'b0;
  logic        m_we     = 1'b0;
  logic [3:0]  m_sel    = '0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  int          m_streak = 0;
  logic [31:0] e_if_data  = '0;
  logic [31:0] e_dm_rdata = '0;

  function automatic logic e_ce();
    return m_left > 1;
  endfunction
  function automatic logic e_if_ack();
    return (m_left == 1) && !m_who_dm;
  endfunction
  function automatic logic e_dm_ack();
    return (m_left == 1) && m_who_dm;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_left = 0; m_who_dm = 1'b0; m_we = 1'b0; m_sel = '0; m_addr = '0; m_wdata = '0;
      m_streak = 0; e_if_data = '0; e_dm_rdata = '0;
    end else if (m_left > 0) begin
      if (m_left == 2) begin
        if (!m_who_dm) e_if_data = mem_rdata_i;
        else if (!m_we) e_dm_rdata = mem_rdata_i;
      end
      m_left--;
    end else begin
      if (!if_req_i) m_streak = 0;
      if (dm_req_i && !(if_req_i && m_streak == DM_MAX)) begin
        m_left = MEM_LAT + 1; m_who_dm = 1'b1;
        m_we = dm_we_i; m_sel = dm_sel_i; m_addr = dm_addr_i; m_wdata = dm_wdata_i;
        if (if_req_i && m_streak < DM_MAX) m_streak++;
      end else if (if_req_i) begin
        m_left = MEM_LAT + 1; m_who_dm = 1'b0;
        m_we = 1'b0; m_sel = 4'b1111; m_addr = if_addr_i; m_wdata = '0;
        m_streak = 0;
      end
    end
  endtask

  // Inputs for the current cycle are already driven; check, clock, check.
  task automatic tick();
    #1;
    chk("stallreq", stallreq_o, (if_req_i & ~e_if_ack()) | (dm_req_i & ~e_dm_ack()));
    model_edge();
    @(posedge clk);
    #1;
    chk("if_ack", if_ack_o, e_if_ack());
    chk("dm_ack", dm_ack_o, e_dm_ack());
    chk("if_data", if_data_o, e_if_data);
    chk("dm_rdata", dm_rdata_o, e_dm_rdata);
    chk("mem_ce", mem_ce_o, e_ce());
    chk("mem_we", mem_we_o, m_we);
    chk("mem_sel", mem_sel_o, m_sel);
    chk("mem_addr", mem_addr_o, m_addr);
    chk("mem_wdata", mem_wdata_o, m_wdata);
  endtask

  initial begin
    bit ack_seq[$];
    bit exp_seq[6];
    bit f_act, d_act;

    rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_sel_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0;
    tick();
    tick();
    chk("rst_ce", mem_ce_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    rst = 1'b0;
    tick();

    // Single fetch
    if_req_i = 1'b1; if_addr_i = 32'h100; mem_rdata_i = 32'h3401_0020;
    tick();
    chk("f_ce_c1", mem_ce_o, 1'b1);
    chk("f_addr_c1", mem_addr_o, 32'h100);
    tick();
    chk("f_ce_c2", mem_ce_o, 1'b1);
    chk("f_sel_c2", mem_sel_o, 4'b1111);
    tick();
    chk("f_ack_c3", if_ack_o, 1'b1);
    chk("f_data_c3", if_data_o, 32'h3401_0020);
    if_req_i = 1'b0;
    tick();
    chk("f_ack_c4", if_ack_o, 1'b0);
    chk("f_data_hold", if_data_o, 32'h3401_0020);

    // Data read, then a write that must leave dm_rdata alone
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hf; dm_addr_i = 32'h2000;
    mem_rdata_i = 32'hCAFE_0001;
    tick(); tick(); tick();
    chk("rd_ack", dm_ack_o, 1'b1);
    chk("rd_data", dm_rdata_o, 32'hCAFE_0001);
    dm_req_i = 1'b0;
    tick();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b0011; dm_addr_i = 32'h2004;
    dm_wdata_i = 32'h0000_BEEF; mem_rdata_i = 32'h1234_5678;
    tick();
    chk("wr_we_c1", mem_we_o, 1'b1);
    chk("wr_sel_c1", mem_sel_o, 4'b0011);
    chk("wr_wdata_c1", mem_wdata_o, 32'h0000_BEEF);
    tick();
    chk("wr_we_c2", mem_we_o, 1'b1);
    tick();
    chk("wr_ack_c3", dm_ack_o, 1'b1);
    chk("wr_rdata_kept", dm_rdata_o, 32'hCAFE_0001);
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    tick();

    // Simultaneous requests: data first, fetch after
    if_req_i = 1'b1; if_addr_i = 32'h200; dm_req_i = 1'b1; dm_addr_i = 32'h3000;
    dm_sel_i = 4'hf; mem_rdata_i = 32'h0BAD_F00D;
    tick(); tick(); tick();
    chk("both_dm_ack_c3", dm_ack_o, 1'b1);
    chk("both_if_ack_c3", if_ack_o, 1'b0);
    dm_req_i = 1'b0;
    tick(); tick(); tick(); tick();
    chk("both_if_ack_c7", if_ack_o, 1'b1);
    if_req_i = 1'b0;
    tick();

    // Starvation limit: both held high continuously
    if_req_i = 1'b1; dm_req_i = 1'b1;
    for (int c = 0; c < 60 && ack_seq.size() < 6; c++) begin
      mem_rdata_i = $urandom;
      dm_addr_i = $urandom & 32'hffff_fffc;
      tick();
      if (if_ack_o === 1'b1) ack_seq.push_back(1'b0);
      if (dm_ack_o === 1'b1) ack_seq.push_back(1'b1);
    end
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    chk("streak_ack_count", ack_seq.size(), 6);
    for (int i = 0; i < 6 && i < ack_seq.size(); i++) chk("streak_order", ack_seq[i], exp_seq[i]);
    if_req_i = 1'b0; dm_req_i = 1'b0;
    tick(); tick(); tick(); tick();

    // Reset in the second access cycle abandons the access
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h4000; mem_rdata_i = 32'h5555_AAAA;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_ack", dm_ack_o, 1'b0);
    chk("rst_mid_ce", mem_ce_o, 1'b0);
    chk("rst_mid_rdata", dm_rdata_o, 32'h0);
    chk("rst_mid_ifdata", if_data_o, 32'h0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rst_after_ack", dm_ack_o, 1'b1);
    chk("rst_after_data", dm_rdata_o, 32'h5555_AAAA);
    dm_req_i = 1'b0;
    tick();

    // Random traffic with occasional resets and mid-access request drops
    f_act = 1'b0; d_act = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = 1'b0;
      if (e_if_ack()) f_act = 1'b0;
      if (e_dm_ack()) d_act = 1'b0;
      if (!f_act) begin
        if_req_i = 1'b0;
        if ($urandom_range(2) == 0) begin
          f_act = 1'b1; if_req_i = 1'b1; if_addr_i = $urandom & 32'hffff_fffc;
        end
      end else if (m_left > 1 && !m_who_dm && $urandom_range(7) == 0) begin
        if_req_i = 1'b0;
      end
      if (!d_act) begin
        dm_req_i = 1'b0;
        if ($urandom_range(1) == 0) begin
          d_act = 1'b1; dm_req_i = 1'b1; dm_we_i = 1'($urandom);
          dm_sel_i = 4'($urandom); dm_addr_i = $urandom; dm_wdata_i = $urandom;
        end
      end else if (m_left > 1 && m_who_dm && $urandom_range(7) == 0) begin
        dm_req_i = 1'b0;
      end
      mem_rdata_i = $urandom;
      if ($urandom_range(59) == 0) rst = 1'b1;
      tick();
      if (rst) begin
        if (!if_req_i) f_act = 1'b0;
        if (!dm_req_i) d_act = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: memory wait states per access, legal range 1..15.
REQ-002 Parameter DM_MAX, default 4: consecutive data grants allowed while fetch waits, legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high (`RstEnable` = 1'b1).
REQ-005 if_req_i  input  1  instruction-fetch request; held high until if_ack_o.
REQ-006 if_addr_i  input  32  fetch byte address.
REQ-007 if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-008 if_data_o  output  32  fetched word; valid while if_ack_o=1.
REQ-009 dm_req_i  input  1  data-memory request; held high until dm_ack_o.
REQ-010 dm_we_i  input  1  1 = write, 0 = read.
REQ-011 dm_sel_i  input  4  byte enables.
REQ-012 dm_addr_i  input  32  data byte address.
REQ-013 dm_wdata_i  input  32  write data.
REQ-014 dm_ack_o  output  1  one-cycle data completion pulse.
REQ-015 dm_rdata_o  output  32  read word; valid while dm_ack_o=1.
REQ-016 mem_ce_o  output  1  memory enable.
REQ-017 mem_we_o  output  1  memory write enable.
REQ-018 mem_sel_o  output  4  memory byte enables.
REQ-019 mem_addr_o  output  32  memory address.
REQ-020 mem_wdata_o  output  32  memory write data.
REQ-021 mem_rdata_i  input  32  memory read data.
REQ-022 stallreq_o  output  1  pipeline stall request to ctrl.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, ACC, RESP.
REQ-024 In IDLE with any request, the next edge SHALL grant, latch the winner's address, we, sel and wdata onto mem_*_o, clear the wait counter and enter ACC.
REQ-025 Fetch grants SHALL drive mem_we_o=0 and mem_sel_o=4'b1111.
REQ-026 mem_ce_o SHALL be 1 only in ACC; mem_* outputs SHALL be registered and stable for all MEM_LAT cycles of ACC.
REQ-027 The wait counter SHALL increment each ACC cycle; at count MEM_LAT-1 the edge SHALL capture mem_rdata_i into the winner's data register and enter RESP.
REQ-028 In RESP the winner's ack SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-029 Latency: request first high in IDLE cycle 0 -> ack in cycle MEM_LAT+1; minimum spacing between grants is MEM_LAT+2 cycles.
REQ-030 Requests SHALL be sampled only in IDLE; a request still high in the IDLE cycle after its ack is a new request.
REQ-031 When both request, data SHALL win unless dm_streak == DM_MAX, in which case fetch SHALL win.
REQ-032 dm_streak SHALL increment on each data grant made while if_req_i=1 (saturating at DM_MAX), and SHALL clear on any fetch grant or any IDLE cycle with if_req_i=0.
REQ-033 A write SHALL still produce dm_ack_o; dm_rdata_o after a write SHALL hold its previous value.
REQ-034 if_data_o and dm_rdata_o SHALL hold their last captured value outside ack cycles.
REQ-035 stallreq_o SHALL be combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
REQ-036 A requester dropping its req mid-access SHALL NOT abort the access; the ack is still issued.
REQ-037 Acks SHALL never be asserted simultaneously, and no ack SHALL occur outside RESP.

Reset
REQ-038 rst=1 at an edge SHALL force IDLE, clear the counter and dm_streak, and zero every output register (acks, data, mem_*) regardless of the current state.
REQ-039 Reset asserted during ACC or RESP SHALL abandon the access with no ack; mem_ce_o SHALL be 0 from the cycle after the reset edge.

Verification
REQ-040 Single fetch: if_req_i=1, if_addr_i=0x100, mem_rdata_i=0x3401_0020 -> mem_ce_o=1 with addr 0x100 in cycles 1-2; if_ack_o=1 and if_data_o=0x3401_0020 in cycle 3.
REQ-041 Data write: dm_we_i=1, sel=4'b0011, addr=0x2004, wdata=0xBEEF -> mem_we_o=1, sel=0011 for 2 cycles; dm_ack_o in cycle 3; dm_rdata_o unchanged.
REQ-042 Simultaneous first requests from both -> data granted first with ack in cycle 3; fetch ack in cycle 7.
REQ-043 Continuous data requests with if_req_i held high, DM_MAX=4 -> exactly 4 data acks, then a fetch ack, then data resumes.
REQ-044 rst pulsed in the second ACC cycle -> no ack, all outputs 0; next request completes normally with MEM_LAT+1 latency.
REQ-045 stallreq_o equals 1 from request cycle through the cycle before ack, 0 in the ack cycle, checked on every scenario.
